// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote, optional parity, 1/2 stop bits.
// Latency: valid pulses 1 clk after the tick that decides the last stop bit.
// Backpressure: none; each committed frame overwrites data and flags.
module uart_rx_param #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 brk
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [SW-1:0] SUB_ONE  = SW'(1);
    localparam logic [SW-1:0] SUB_PRE  = SW'(M - 1);
    localparam logic [SW-1:0] SUB_MID  = SW'(M);
    localparam logic [SW-1:0] SUB_DEC  = SW'(M + 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [SW-1:0]          r_sub;
    logic [3:0]             r_bitcnt;
    logic                   r_samp_a;
    logic                   r_samp_b;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_pbit;
    logic                   r_ferr_acc;
    logic                   r_commit;
    logic                   w_commit;
    logic                   w_rx_s;
    logic                   w_dec;
    logic                   w_wrap;
    logic                   w_maj;
    logic                   w_par_x;
    logic                   w_perr;
    logic                   w_brk;

    assign w_rx_s  = r_sync2;
    assign w_dec   = tick && (r_sub == SUB_DEC);
    assign w_wrap  = tick && (r_sub == SUB_LAST);
    assign w_maj   = (r_samp_a & r_samp_b) | (r_samp_a & w_rx_s) | (r_samp_b & w_rx_s);
    assign w_par_x = (^r_shift) ^ r_pbit;
    assign w_perr  = (PARITY == 1) ? ~w_par_x : (PARITY == 2) ? w_par_x : 1'b0;
    assign w_brk   = r_ferr_acc && (r_shift == '0) && ((PARITY == 0) || !r_pbit);

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE:  if (tick && !w_rx_s) w_state_nxt = S_START;
            S_START: begin
                if (w_dec && w_maj)   w_state_nxt = S_IDLE;
                else if (w_wrap)      w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_wrap && r_bitcnt == 4'(DATA_BITS))
                    w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR:   if (w_wrap) w_state_nxt = S_STOP;
            S_STOP: begin
                // Leave mid-stop-bit on a clean frame so a start bit half a bit later is caught.
                if (w_dec && r_bitcnt == 4'(STOP_BITS - 1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = (r_ferr_acc || !w_maj) ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT:  if (tick && w_rx_s) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
            r_sub   <= '0;
            r_bitcnt   <= '0;
            r_samp_a   <= 1'b1;
            r_samp_b   <= 1'b1;
            r_shift    <= '0;
            r_pbit     <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_commit   <= 1'b0;
        end else begin
            r_sync1  <= rx;
            r_sync2  <= r_sync1;
            r_commit <= w_commit;
            if (tick) begin
                r_state <= w_state_nxt;
                // The start-detect tick is bit position 0, so the counter resumes at 1.
                if (r_state == S_IDLE)       r_sub <= SUB_ONE;
                else if (r_sub == SUB_LAST)  r_sub <= '0;
                else                         r_sub <= r_sub + SUB_ONE;
                if (w_state_nxt != r_state)
                    r_bitcnt <= '0;
                else if (w_dec && (r_state == S_DATA || r_state == S_STOP))
                    r_bitcnt <= r_bitcnt + 4'd1;
                if (r_sub == SUB_PRE) r_samp_a <= w_rx_s;
                if (r_sub == SUB_MID) r_samp_b <= w_rx_s;
                if (w_dec && r_state == S_DATA) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                if (w_dec && r_state == S_PAR)  r_pbit  <= w_maj;
                if (r_state == S_IDLE)
                    r_ferr_acc <= 1'b0;
                else if (w_dec && r_state == S_STOP && !w_maj)
                    r_ferr_acc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            brk        <= 1'b0;
        end else begin
            valid <= r_commit;
            if (r_commit) begin
                data       <= r_shift;
                parity_err <= w_perr;
                frame_err  <= r_ferr_acc;
                brk        <= w_brk;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: two instances (8N1 and 8E2) fed by line-level frame tasks.
// A negedge monitor pops the expected-frame queue on every valid pulse.
module tb_uart_rx_param;
    localparam int OS  = 16;
    localparam int M   = OS / 2;
    // 2 synchroniser clks + 1 to the start-detect edge + 153 ticks to the last stop decision + 1 commit clk
    localparam int LAT = 2 + 1 + (9 * OS + M + 1) + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] data0, data1;
    logic       v0, v1, pe0, pe1, fe0, fe1, bk0, bk1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tick_div = 1;
    int   vcyc0 = -1;
    int   c0;
    exp_t q0[$];
    exp_t q1[$];

    uart_rx_param #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx0), .data(data0), .valid(v0),
        .parity_err(pe0), .frame_err(fe0), .brk(bk0));

    uart_rx_param #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx1), .data(data1), .valid(v1),
        .parity_err(pe1), .frame_err(fe1), .brk(bk1));

    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    initial begin : tick_gen
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tick = (tcnt == 0);
            tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input int sel, input logic [7:0] d, input logic pe, input logic fe, input logic bk);
        exp_t e;
        int   n;
        n = (sel == 0) ? q0.size() : q1.size();
        chk($sformatf("valid%0d_expected", sel), n, (n == 0) ? 32'd1 : 32'(n));
        if (n != 0) begin
            e = (sel == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("data%0d", sel), d, e.d);
            chk($sformatf("parity_err%0d", sel), pe, e.pe);
            chk($sformatf("frame_err%0d", sel), fe, e.fe);
            chk($sformatf("brk%0d", sel), bk, e.bk);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (v0) begin
            vcyc0 = cyc;
            pop_chk(0, data0, pe0, fe0, bk0);
        end
        if (v1) pop_chk(1, data1, pe1, fe1, bk1);
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic send_bit(input int sel, input logic v, input bit spike);
        set_rx(sel, v);
        if (spike) begin
            wait_ticks(M);
            set_rx(sel, ~v);
            wait_ticks(1);
            set_rx(sel, v);
            wait_ticks(OS - M - 1);
        end else begin
            wait_ticks(OS);
        end
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par, input logic pbit,
                              input int nstop, input logic [1:0] stopv, input int spike_bit);
        send_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], i == spike_bit);
        if (has_par) send_bit(sel, pbit, 1'b0);
        for (int i = 0; i < nstop; i++) send_bit(sel, stopv[i], 1'b0);
    endtask

    task automatic push(input int sel, input logic [7:0] d, input logic pe, input logic fe, input logic bk);
        exp_t e;
        e = '{d: d, pe: pe, fe: fe, bk: bk};
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
        #1;
        chk(tag, q0.size() + q1.size(), 0);
    endtask

    // Even-parity error flag for a given data byte and received parity bit.
    function automatic logic even_perr(input logic [7:0] d, input logic pbit);
        return (^d) ^ pbit;
    endfunction

    initial begin
        #23;
        chk("rst_data0", data0, 0);
        chk("rst_valid0", v0, 0);
        chk("rst_flags0", {pe0, fe0, bk0}, 0);
        chk("rst_data1", data1, 0);
        chk("rst_flags1", {v1, pe1, fe1, bk1}, 0);
        rst_n = 1'b1;
        wait_ticks(20);

        c0 = cyc;
        push(0, 8'hA5, 0, 0, 0);
        send_frame(0, 8'hA5, 0, 0, 1, 2'b11, -1);
        chk("latency_a5", vcyc0 - c0, LAT);
        wait_ticks(40);
        chk("hold_data0", data0, 8'hA5);

        rx0 = 1'b0;
        wait_ticks(5);
        rx0 = 1'b1;
        wait_ticks(40);
        push(0, 8'h3C, 0, 0, 0);
        send_frame(0, 8'h3C, 0, 0, 1, 2'b11, 2);
        wait_drain("drain_3c", 200);

        push(0, 8'h55, 0, 1, 0);
        send_frame(0, 8'h55, 0, 0, 1, 2'b00, -1);
        rx0 = 1'b1;
        wait_ticks(20);
        push(0, 8'h12, 0, 0, 0);
        send_frame(0, 8'h12, 0, 0, 1, 2'b11, -1);
        wait_drain("drain_ferr", 200);

        push(0, 8'h00, 0, 1, 1);
        rx0 = 1'b0;
        wait_ticks(3 * 10 * OS);
        chk("brk_hold", {fe0, bk0}, 2'b11);
        rx0 = 1'b1;
        wait_ticks(40);
        wait_drain("drain_brk", 50);

        push(1, 8'h07, even_perr(8'h07, 1'b0), 0, 0);
        send_frame(1, 8'h07, 1, 1'b0, 2, 2'b11, -1);
        push(1, 8'h07, even_perr(8'h07, 1'b1), 0, 0);
        send_frame(1, 8'h07, 1, 1'b1, 2, 2'b11, -1);
        wait_drain("drain_par", 200);
        chk("perr_clear", pe1, 0);
        push(1, 8'h80, 0, 1, 0);
        send_frame(1, 8'h80, 1, 1'b1, 2, 2'b01, -1);
        rx1 = 1'b1;
        wait_ticks(20);
        wait_drain("drain_stop2", 50);

        tick_div = 3;
        wait_ticks(4);
        push(0, 8'h01, 0, 0, 0);
        push(0, 8'hFE, 0, 0, 0);
        send_frame(0, 8'h01, 0, 0, 1, 2'b11, -1);
        send_frame(0, 8'hFE, 0, 0, 1, 2'b11, -1);
        push(1, 8'h01, 0, 0, 0);
        push(1, 8'hFE, 0, 0, 0);
        send_frame(1, 8'h01, 1, 1'b1, 2, 2'b11, -1);
        send_frame(1, 8'hFE, 1, 1'b1, 2, 2'b11, -1);
        wait_drain("drain_b2b", 300);
        tick_div = 1;
        wait_ticks(4);

        send_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, i == 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_data0", data0, 0);
        chk("midrst_flags0", {v0, pe0, fe0, bk0}, 0);
        chk("midrst_data1", data1, 0);
        rx0 = 1'b1;
        #20;
        rst_n = 1'b1;
        wait_ticks(8 * OS);
        push(0, 8'h81, 0, 0, 0);
        send_frame(0, 8'h81, 0, 0, 1, 2'b11, -1);
        wait_drain("drain_81", 200);
        chk("final_data0", data0, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
